// File: rtl/intt_8point_iter_if.sv
// Start/data handshake bus of the 8-point iterative inverse NTT engine.
// master drives the job request, slave (the engine) returns status and result.
interface intt_8point_iter_if #(
    parameter int WIDTH = 8
);
    logic                  start;
    logic [7:0][WIDTH-1:0] data_in;
    logic [WIDTH-1:0]      omega_inv;
    logic [WIDTH-1:0]      mod;
    logic [WIDTH-1:0]      n_inv;
    logic                  busy;
    logic                  done;
    logic [7:0][WIDTH-1:0] data_out;

    modport master (
        output start, data_in, omega_inv, mod, n_inv,
        input  busy, done, data_out
    );

    modport slave (
        input  start, data_in, omega_inv, mod, n_inv,
        output busy, done, data_out
    );
endinterface

// File: rtl/intt_8point_iter.sv
// Sequential 8-point inverse NTT: bit-reversed load, 3 radix-2 DIT stages, one butterfly per cycle.
// Define INTT_SCALE_EN to add the final n_inv scaling pass (SCALE state).
//
// state | meaning
// IDLE  | waiting for start; captures coefficients (bit-reversed) and parameters
// TWID  | 2 cycles: w2 = w1*w1, then w3 = w2*w1
// BFLY  | 12 cycles: one butterfly per cycle, 3 stages of 4
// SCALE | 8 cycles: a[e] *= n_inv (only with INTT_SCALE_EN)
// DONE  | 1 cycle: data_out updated, done pulse
module intt_8point_iter #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    intt_8point_iter_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TWID  = 3'd1;
    localparam logic [2:0] S_BFLY  = 3'd2;
`ifdef INTT_SCALE_EN
    localparam logic [2:0] S_SCALE = 3'd3;
`endif
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [7:0][WIDTH-1:0] a_q, a_d;
    logic [3:0][WIDTH-1:0] w_q, w_d;
    logic [WIDTH-1:0]      mod_q, mod_d;
    logic [7:0][WIDTH-1:0] dout_q, dout_d;
`ifdef INTT_SCALE_EN
    logic [WIDTH-1:0]      ninv_q, ninv_d;
`endif

    logic [2:0]            lo_idx, hi_idx;
    logic [1:0]            tw_idx;
    logic [WIDTH-1:0]      mul_a, mul_b, mul_r;
    logic [2*WIDTH-1:0]    prod;
    logic [WIDTH-1:0]      u;
    logic [WIDTH:0]        sum_raw, dif_raw;
    logic [WIDTH-1:0]      sum_m, dif_m;

    function automatic logic [2:0] bitrev3(input logic [2:0] x);
        return {x[0], x[1], x[2]};
    endfunction

    // Butterfly pair and twiddle index from counter: stage = cnt[3:2], index p = cnt[1:0]
    always_comb begin
        lo_idx = 3'd0;
        hi_idx = 3'd0;
        tw_idx = 2'd0;
        case (cnt_q[3:2])
            2'd0: begin
                lo_idx = {cnt_q[1:0], 1'b0};
                hi_idx = {cnt_q[1:0], 1'b1};
                tw_idx = 2'd0;
            end
            2'd1: begin
                lo_idx = {cnt_q[1], 1'b0, cnt_q[0]};
                hi_idx = {cnt_q[1], 1'b1, cnt_q[0]};
                tw_idx = {cnt_q[0], 1'b0};
            end
            default: begin
                lo_idx = {1'b0, cnt_q[1:0]};
                hi_idx = {1'b1, cnt_q[1:0]};
                tw_idx = cnt_q[1:0];
            end
        endcase
    end

    // Single shared modular multiplier, operands chosen by state
    always_comb begin
        mul_a = a_q[hi_idx];
        mul_b = w_q[tw_idx];
        case (state_q)
            S_TWID: begin
                mul_a = cnt_q[0] ? w_q[2] : w_q[1];
                mul_b = w_q[1];
            end
`ifdef INTT_SCALE_EN
            S_SCALE: begin
                mul_a = a_q[cnt_q[2:0]];
                mul_b = ninv_q;
            end
`endif
            default: ;
        endcase
    end

    assign prod  = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
    assign mul_r = WIDTH'(prod % {{WIDTH{1'b0}}, mod_q});

    assign u       = a_q[lo_idx];
    assign sum_raw = {1'b0, u} + {1'b0, mul_r};
    assign dif_raw = {1'b0, u} + {1'b0, mod_q} - {1'b0, mul_r};
    assign sum_m   = (sum_raw >= {1'b0, mod_q}) ? WIDTH'(sum_raw - {1'b0, mod_q}) : sum_raw[WIDTH-1:0];
    assign dif_m   = (dif_raw >= {1'b0, mod_q}) ? WIDTH'(dif_raw - {1'b0, mod_q}) : dif_raw[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        w_d     = w_q;
        mod_d   = mod_q;
        dout_d  = dout_q;
`ifdef INTT_SCALE_EN
        ninv_d  = ninv_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    for (int i = 0; i < 8; i++) begin
                        a_d[i] = bus.data_in[bitrev3(3'(i))];
                    end
                    w_d[0]  = WIDTH'(1);
                    w_d[1]  = bus.omega_inv;
                    w_d[2]  = '0;
                    w_d[3]  = '0;
                    mod_d   = bus.mod;
`ifdef INTT_SCALE_EN
                    ninv_d  = bus.n_inv;
`endif
                    cnt_d   = 4'd0;
                    state_d = S_TWID;
                end
            end
            S_TWID: begin
                if (cnt_q[0]) begin
                    w_d[3]  = mul_r;
                    cnt_d   = 4'd0;
                    state_d = S_BFLY;
                end else begin
                    w_d[2] = mul_r;
                    cnt_d  = 4'd1;
                end
            end
            S_BFLY: begin
                a_d[lo_idx] = sum_m;
                a_d[hi_idx] = dif_m;
                if (cnt_q == 4'd11) begin
                    cnt_d = 4'd0;
`ifdef INTT_SCALE_EN
                    state_d = S_SCALE;
`else
                    state_d = S_DONE;
                    dout_d  = a_d;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
`ifdef INTT_SCALE_EN
            S_SCALE: begin
                a_d[cnt_q[2:0]] = mul_r;
                if (cnt_q == 4'd7) begin
                    cnt_d   = 4'd0;
                    state_d = S_DONE;
                    dout_d  = a_d;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            w_q     <= '0;
            mod_q   <= '0;
            dout_q  <= '0;
`ifdef INTT_SCALE_EN
            ninv_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            w_q     <= w_d;
            mod_q   <= mod_d;
            dout_q  <= dout_d;
`ifdef INTT_SCALE_EN
            ninv_q  <= ninv_d;
`endif
        end
    end

    assign bus.busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.data_out = dout_q;
endmodule

// File: tb/tb_intt_8point_iter.sv
// Self-checking bench for intt_8point_iter: directed table, random jobs against a direct inverse-DFT model,
// and hand sequences for back-to-back starts, mid-job disturbance and mid-job reset.
module tb_intt_8point_iter;
    localparam int W = 8;
`ifdef INTT_SCALE_EN
    localparam int DONE_CYC = 23;
    localparam bit SCALED   = 1'b1;
`else
    localparam int DONE_CYC = 15;
    localparam bit SCALED   = 1'b0;
`endif
    localparam int PERIOD = DONE_CYC + 1;

    typedef logic [7:0][W-1:0] vec_t;
    typedef struct {
        string name;
        vec_t  din;
        vec_t  exp;
    } vector_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    intt_8point_iter_if #(.WIDTH(W)) intf ();
    intt_8point_iter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(intf));

    int vectors     = 0;
    int miscompares = 0;
    int primes[10]  = '{17, 41, 73, 89, 97, 113, 137, 193, 233, 241};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int powmod(input int b, input int e, input int q);
        int r;
        r = 1 % q;
        for (int i = 0; i < e; i++) r = (r * b) % q;
        return r;
    endfunction

    // Direct transform X[n] = sum_k x[k] * w^(k*n) mod q
    function automatic vec_t dft(input vec_t x, input int w, input int q);
        vec_t y;
        int acc;
        for (int n = 0; n < 8; n++) begin
            acc = 0;
            for (int k = 0; k < 8; k++) acc = (acc + int'(x[k]) * powmod(w, (k * n) % 8, q)) % q;
            y[n] = W'(acc);
        end
        return y;
    endfunction

    function automatic vec_t intt_model(input vec_t x, input int wi, input int q, input int ni);
        vec_t y;
        y = dft(x, wi, q);
        if (SCALED) begin
            for (int n = 0; n < 8; n++) y[n] = W'((int'(y[n]) * ni) % q);
        end
        return y;
    endfunction

    function automatic vec_t mk8(input int v[8]);
        vec_t y;
        for (int i = 0; i < 8; i++) y[i] = W'(v[i]);
        return y;
    endfunction

    task automatic rand_params(output int q, output int wi, output int ni);
        int off, g, r;
        q   = primes[$urandom_range(0, 9)];
        wi  = 0;
        ni  = 0;
        off = $urandom_range(0, q - 3);
        for (int i = 0; i < q && wi == 0; i++) begin
            g = 2 + (off + i) % (q - 2);
            r = powmod(g, (q - 1) / 8, q);
            if (powmod(r, 4, q) == q - 1) wi = r;
        end
        for (int x = 1; x < q; x++) if ((8 * x) % q == 1) ni = x;
    endtask

    task automatic run_job(input vec_t din, input int wi, input int q, input int ni, input bit disturb,
                           output vec_t res, output int done_cyc, output int ndone, output int busy_bad);
        vec_t junk;
        res      = '0;
        done_cyc = -1;
        ndone    = 0;
        busy_bad = 0;
        @(negedge clk);
        intf.data_in   = din;
        intf.omega_inv = W'(wi);
        intf.mod       = W'(q);
        intf.n_inv     = W'(ni);
        intf.start     = 1'b1;
        @(posedge clk);
        #1;
        intf.start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (intf.busy !== (cyc < DONE_CYC)) busy_bad++;
            if (intf.done === 1'b1) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    res      = intf.data_out;
                end
            end
            if (disturb && cyc == 5) begin
                for (int i = 0; i < 8; i++) junk[i] = W'($urandom_range(0, 12));
                intf.start   = 1'b1;
                intf.data_in = junk;
                intf.mod     = 8'd13;
            end
            if (disturb && cyc == 6) intf.start = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic job_and_check(input string name, input vec_t din, input int wi, input int q, input int ni,
                                 input vec_t exp, input bit disturb);
        vec_t res;
        int dc, nd, bb;
        run_job(din, wi, q, ni, disturb, res, dc, nd, bb);
        check({name, "_data"}, res, exp);
        check({name, "_done_cycle"}, 64'(dc), 64'(DONE_CYC));
        check({name, "_done_count"}, 64'(nd), 64'd1);
        check({name, "_busy_errors"}, 64'(bb), 64'd0);
    endtask

    initial begin
        vector_t tbl[4];
        vec_t    din, exp;
        int      q, wi, ni, nd, first, second, bb;

        intf.start     = 1'b0;
        intf.data_in   = '0;
        intf.omega_inv = '0;
        intf.mod       = '0;
        intf.n_inv     = '0;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(intf.busy), 64'd0);
        check("reset_done", 64'(intf.done), 64'd0);
        check("reset_data_out", intf.data_out, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0].name = "impulse0";
        tbl[0].din  = mk8('{1, 0, 0, 0, 0, 0, 0, 0});
        tbl[0].exp  = SCALED ? mk8('{15, 15, 15, 15, 15, 15, 15, 15}) : mk8('{1, 1, 1, 1, 1, 1, 1, 1});
        tbl[1].name = "const5";
        tbl[1].din  = mk8('{5, 5, 5, 5, 5, 5, 5, 5});
        tbl[1].exp  = SCALED ? mk8('{5, 0, 0, 0, 0, 0, 0, 0}) : mk8('{6, 0, 0, 0, 0, 0, 0, 0});
        tbl[2].name = "impulse1";
        tbl[2].din  = mk8('{0, 1, 0, 0, 0, 0, 0, 0});
        tbl[2].exp  = SCALED ? mk8('{15, 16, 8, 4, 2, 1, 9, 13}) : mk8('{1, 9, 13, 15, 16, 8, 4, 2});
        tbl[3].name = "roundtrip";
        tbl[3].din  = dft(mk8('{1, 2, 3, 4, 5, 6, 7, 8}), 2, 17);
        tbl[3].exp  = SCALED ? mk8('{1, 2, 3, 4, 5, 6, 7, 8}) : mk8('{8, 16, 7, 15, 6, 14, 5, 13});

        for (int i = 0; i < 4; i++) job_and_check(tbl[i].name, tbl[i].din, 9, 17, 15, tbl[i].exp, 1'b0);

        for (int r = 0; r < 12; r++) begin
            rand_params(q, wi, ni);
            for (int i = 0; i < 8; i++) din[i] = W'($urandom_range(0, q - 1));
            exp = intt_model(din, wi, q, ni);
            job_and_check($sformatf("rand%0d_q%0d", r, q), din, wi, q, ni, exp, 1'b0);
        end

        // start and inputs disturbed mid-job must not restart or corrupt the job
        job_and_check("disturbed", tbl[2].din, 9, 17, 15, tbl[2].exp, 1'b1);

        // start held high: one transform every PERIOD cycles
        @(negedge clk);
        intf.data_in   = tbl[3].din;
        intf.omega_inv = 8'd9;
        intf.mod       = 8'd17;
        intf.n_inv     = 8'd15;
        intf.start     = 1'b1;
        @(posedge clk);
        #1;
        nd = 0; first = -1; second = -1;
        for (int cyc = 1; cyc <= 3 * PERIOD; cyc++) begin
            if (intf.done === 1'b1) begin
                nd++;
                check("b2b_data", intf.data_out, tbl[3].exp);
                if (nd == 1) first = cyc;
                if (nd == 2) begin
                    second     = cyc;
                    intf.start = 1'b0;
                end
            end
            @(posedge clk);
            #1;
        end
        intf.start = 1'b0;
        check("b2b_done_count", 64'(nd), 64'd2);
        check("b2b_first_done", 64'(first), 64'(DONE_CYC));
        check("b2b_spacing", 64'(second - first), 64'(PERIOD));

        // reset asserted in cycle t+10 aborts the job
        @(negedge clk);
        intf.data_in = tbl[0].din;
        intf.start   = 1'b1;
        @(posedge clk);
        #1;
        intf.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(intf.busy), 64'd0);
        check("abort_done", 64'(intf.done), 64'd0);
        check("abort_data_out", intf.data_out, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0; bb = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk);
            #1;
            if (intf.done === 1'b1) nd++;
            if (intf.busy !== 1'b0) bb++;
        end
        check("abort_no_done", 64'(nd), 64'd0);
        check("abort_no_busy", 64'(bb), 64'd0);
        job_and_check("after_abort", tbl[2].din, 9, 17, 15, tbl[2].exp, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
